obi_mem_arbiter: RTL and testbench
==================================

Name: obi_mem_arbiter

Overview:
- Shares one OBI-style memory port between two requesters: the load/store unit (port 0, LSU) and the instruction fetch unit (port 1, IF).
- Allows one outstanding transaction at a time and locks the grant from address phase to response.
- Routes the response handshake back to the requester that issued the transaction.
- Sits between the core's LSU/fetch stages and the external memory interface.

Parameters:
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority, LSU always wins.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- lsu_req_i  in  1  LSU request.
- lsu_addr_i  in  AW  LSU address.
- lsu_we_i  in  1  LSU write enable.
- lsu_wdata_i  in  DW  LSU write data.
- lsu_rdy_o  out  1  LSU address phase accepted.
- lsu_valid_o  out  1  LSU response valid.
- lsu_rdata_o  out  DW  LSU read data.
- if_req_i  in  1  fetch request (read only).
- if_addr_i  in  AW  fetch address.
- if_rdy_o  out  1  fetch address phase accepted.
- if_valid_o  out  1  fetch response valid.
- if_rdata_o  out  DW  fetch read data.
- mem_req_o  out  1  request to memory.
- mem_addr_o  out  AW  memory address.
- mem_we_o  out  1  memory write enable.
- mem_wdata_o  out  DW  memory write data.
- mem_rdy_i  in  1  memory accepts address phase.
- mem_valid_i  in  1  memory response valid.
- mem_rdata_i  in  DW  memory read data.
- busy_o  out  1  arbiter not in IDLE.

Behaviour:
- State machine states are IDLE, ADDR (waiting for mem_rdy_i) and RESP (waiting for mem_valid_i).
- Registers are state, owner (0 = LSU, 1 = IF) and last (last granted port).
- Reset (RST=1 at a clock edge): state=IDLE, owner=0, last=1, so the LSU wins the first tie.
- Reset values of outputs: all rdy/valid outputs are 0 and mem_req_o=0 while no request is present.
- Address/data mux:
  - mem_addr_o, mem_we_o and mem_wdata_o come from the selected port (IDLE) or from owner (ADDR/RESP).
  - When IF is selected, mem_we_o=0 and mem_wdata_o=0.
- Selection in IDLE is combinational:
  - Only one port requesting: that port is selected.
  - Both requesting, RR_EN=1: the port != last is selected.
  - Both requesting, RR_EN=0: LSU is selected.
- IDLE with a selected port:
  - mem_req_o=1 in the same cycle, giving zero added latency.
  - The selected port's rdy_o = mem_rdy_i.
  - owner and last are updated to the selected port.
  - Next state is RESP if mem_rdy_i=1, else ADDR.
- ADDR:
  - mem_req_o=1 regardless of the owner's req_i.
  - The owner must hold addr/we/wdata stable; this is not checked.
  - Owner rdy_o = mem_rdy_i.
  - On mem_rdy_i=1, go to RESP.
  - The other port's requests are ignored; its rdy_o stays 0.
- RESP:
  - mem_req_o=0.
  - On mem_valid_i=1: owner valid_o=1 in that cycle (combinational pass-through), then go to IDLE.
  - No new grant is made in the valid cycle. Back-to-back transactions therefore cost one idle cycle between response and the next request: minimum 2 cycles per transaction with a zero-wait memory.
- rdata: lsu_rdata_o and if_rdata_o are both driven by mem_rdata_i. Each requester may only sample it when its own valid_o=1.
- Non-owner valid_o is always 0.
- mem_valid_i in IDLE or ADDR is ignored and never forwarded.
- Reset mid-transaction: return to IDLE, drop the in-flight response and drive no valid_o for it.
- Requester withdrawing req_i in IDLE before grant: nothing is latched and no state change occurs.
- busy_o=1 in ADDR and RESP, and in IDLE when any req_i=1.

Test Plan:
- Single LSU write: lsu_req_i=1, addr=0x100, we=1, wdata=0xDEADBEEF, mem_rdy_i=1 same cycle, mem_valid_i next cycle -> mem_req_o=1 cycle 0 with those values; lsu_valid_o=1 cycle 1; if_valid_o=0 throughout.
- Simultaneous requests after reset, RR_EN=1, zero-wait memory: both req held 4 transactions -> grant order LSU, IF, LSU, IF; each grant 2 cycles apart.
- Same stimulus with RR_EN=0 -> all 4 grants go to LSU; IF never granted while lsu_req_i=1.
- Memory stall: IF fetch addr=0x40, mem_rdy_i=0 for 3 cycles, lsu_req_i asserted in cycle 1 -> mem_addr_o stays 0x40 and mem_req_o=1 for 4 cycles; lsu_rdy_o=0; LSU granted only after the IF response.
- Read data routing: IF read, mem_rdata_i=0x12345678 with mem_valid_i=1 -> if_valid_o=1 and if_rdata_o=0x12345678; lsu_valid_o=0.
- Reset in RESP: RST=1 while waiting for valid, then mem_valid_i=1 one cycle after reset release -> state IDLE; no valid_o asserted; busy_o=0.

Source files
------------

// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter
//   Shares one OBI-style memory port between the load/store unit (port 0)
//   and the instruction fetch unit (port 1). Only one transaction is in
//   flight at a time. The grant is locked from the address phase until the
//   response returns, and the response handshake is routed back to the
//   port that issued the transaction.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   lsu_*               LSU request/address/we/wdata in; rdy/valid/rdata out
//   if_*                fetch request/address in (read only); rdy/valid/rdata out
//   mem_*               shared memory port: req/addr/we/wdata out;
//                       rdy/valid/rdata in
//   busy_o              arbiter not idle, or a request is pending
module obi_mem_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          CLK,
  input  logic          RST,
  // LSU port
  input  logic          lsu_req_i,
  input  logic [AW-1:0] lsu_addr_i,
  input  logic          lsu_we_i,
  input  logic [DW-1:0] lsu_wdata_i,
  output logic          lsu_rdy_o,
  output logic          lsu_valid_o,
  output logic [DW-1:0] lsu_rdata_o,
  // fetch port
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_rdy_o,
  output logic          if_valid_o,
  output logic [DW-1:0] if_rdata_o,
  // memory port
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_rdy_i,
  input  logic          mem_valid_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt;   // 0 = LSU, 1 = IF
  logic   last,  last_nxt;    // last granted port
  logic   any_req;
  logic   sel;                // port picked in IDLE
  logic   port;               // port currently driving the memory bus

  // Selection is purely combinational so a request in IDLE reaches memory
  // in the same cycle.
  always_comb begin
    any_req = lsu_req_i | if_req_i;
    if (lsu_req_i && if_req_i) sel = RR_EN ? ~last : 1'b0;
    else                       sel = if_req_i;
    port = (state == IDLE) ? sel : owner;
  end

  // Fetch is read only: force we/wdata low whenever IF drives the bus.
  assign mem_addr_o  = port ? if_addr_i : lsu_addr_i;
  assign mem_we_o    = ~port & lsu_we_i;
  assign mem_wdata_o = port ? '0 : lsu_wdata_i;

  // Read data is broadcast; only the port seeing valid may sample it.
  assign lsu_rdata_o = mem_rdata_i;
  assign if_rdata_o  = mem_rdata_i;

  assign busy_o = (state != IDLE) | any_req;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;   // LSU wins the first tie
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    last_nxt    = last;
    mem_req_o   = 1'b0;
    lsu_rdy_o   = 1'b0;
    if_rdy_o    = 1'b0;
    lsu_valid_o = 1'b0;
    if_valid_o  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          mem_req_o = 1'b1;
          lsu_rdy_o = ~sel & mem_rdy_i;
          if_rdy_o  =  sel & mem_rdy_i;
          owner_nxt = sel;
          last_nxt  = sel;
          state_nxt = mem_rdy_i ? RESP : ADDR;
        end
      end
      ADDR: begin
        // Grant is locked: owner's req_i no longer matters, the other
        // port waits.
        mem_req_o = 1'b1;
        lsu_rdy_o = ~owner & mem_rdy_i;
        if_rdy_o  =  owner & mem_rdy_i;
        if (mem_rdy_i) state_nxt = RESP;
      end
      RESP: begin
        // No new grant in the valid cycle; the next request waits for IDLE.
        if (mem_valid_i) begin
          lsu_valid_o = ~owner;
          if_valid_o  =  owner;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
module tb_obi_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        lsu_req, lsu_we, if_req, mem_rdy, mem_valid;
  logic [31:0] lsu_addr, lsu_wdata, if_addr, mem_rdata;

  // index 0: RR_EN=1 instance, index 1: RR_EN=0 instance (shared inputs)
  logic [1:0]       l_rdy, l_vld, i_rdy, i_vld, m_req, m_we, bsy;
  logic [1:0][31:0] l_rdata, i_rdata, m_addr, m_wdata;

  always #5 CLK = ~CLK;

  obi_mem_arbiter #(.RR_EN(1'b1), .AW(32), .DW(32)) dut_rr (
    .CLK(CLK), .RST(RST),
    .lsu_req_i(lsu_req), .lsu_addr_i(lsu_addr), .lsu_we_i(lsu_we), .lsu_wdata_i(lsu_wdata),
    .lsu_rdy_o(l_rdy[0]), .lsu_valid_o(l_vld[0]), .lsu_rdata_o(l_rdata[0]),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_rdy_o(i_rdy[0]), .if_valid_o(i_vld[0]), .if_rdata_o(i_rdata[0]),
    .mem_req_o(m_req[0]), .mem_addr_o(m_addr[0]), .mem_we_o(m_we[0]), .mem_wdata_o(m_wdata[0]),
    .mem_rdy_i(mem_rdy), .mem_valid_i(mem_valid), .mem_rdata_i(mem_rdata),
    .busy_o(bsy[0])
  );

  obi_mem_arbiter #(.RR_EN(1'b0), .AW(32), .DW(32)) dut_fp (
    .CLK(CLK), .RST(RST),
    .lsu_req_i(lsu_req), .lsu_addr_i(lsu_addr), .lsu_we_i(lsu_we), .lsu_wdata_i(lsu_wdata),
    .lsu_rdy_o(l_rdy[1]), .lsu_valid_o(l_vld[1]), .lsu_rdata_o(l_rdata[1]),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_rdy_o(i_rdy[1]), .if_valid_o(i_vld[1]), .if_rdata_o(i_rdata[1]),
    .mem_req_o(m_req[1]), .mem_addr_o(m_addr[1]), .mem_we_o(m_we[1]), .mem_wdata_o(m_wdata[1]),
    .mem_rdy_i(mem_rdy), .mem_valid_i(mem_valid), .mem_rdata_i(mem_rdata),
    .busy_o(bsy[1])
  );

  typedef struct {
    bit          port;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          gap;    // cycles since previous grant, 0 = don't care
  } gnt_t;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
  } rsp_t;

  gnt_t gq0[$], gq1[$];
  rsp_t rq0[$], rq1[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   last_g[2] = '{0, 0};

  task automatic push_g(input int k, input bit p, input logic [31:0] a,
                        input logic w, input logic [31:0] d, input int gap);
    gnt_t g;
    g.port = p; g.addr = a; g.we = w; g.wdata = d; g.gap = gap;
    if (k == 0) gq0.push_back(g); else gq1.push_back(g);
  endtask

  task automatic push_r(input int k, input bit p, input logic [31:0] d);
    rsp_t r;
    r.port = p; r.rdata = d;
    if (k == 0) rq0.push_back(r); else rq1.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  // Monitor: address handshakes and responses are popped from the
  // scoreboard queues and compared.
  always @(negedge CLK) begin
    gnt_t e;
    rsp_t r;
    bit   have;
    bit   ok;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (m_req[k] && mem_rdy) begin
        have = 1'b0;
        if (k == 0) begin if (gq0.size() > 0) begin e = gq0.pop_front(); have = 1'b1; end end
        else        begin if (gq1.size() > 0) begin e = gq1.pop_front(); have = 1'b1; end end
        n_chk++;
        if (!have) begin
          n_err++;
          $display("FAIL grant[%0d]: unexpected handshake addr=%h, expected none", k, m_addr[k]);
        end else begin
          ok = (i_rdy[k] == e.port) && ((l_rdy[k] ^ i_rdy[k]) == 1'b1) &&
               (m_addr[k] == e.addr) && (m_we[k] == e.we) && (m_wdata[k] == e.wdata) &&
               (e.gap == 0 || (cyc - last_g[k]) == e.gap);
          if (!ok) begin
            n_err++;
            $display("FAIL grant[%0d]: got port=%0d lrdy=%0d addr=%h we=%0d wdata=%h gap=%0d, expected port=%0d addr=%h we=%0d wdata=%h gap=%0d",
                     k, i_rdy[k], l_rdy[k], m_addr[k], m_we[k], m_wdata[k], cyc - last_g[k],
                     e.port, e.addr, e.we, e.wdata, e.gap);
          end
        end
        last_g[k] = cyc;
      end
      if (l_vld[k] || i_vld[k]) begin
        have = 1'b0;
        if (k == 0) begin if (rq0.size() > 0) begin r = rq0.pop_front(); have = 1'b1; end end
        else        begin if (rq1.size() > 0) begin r = rq1.pop_front(); have = 1'b1; end end
        n_chk++;
        if (!have) begin
          n_err++;
          $display("FAIL resp[%0d]: unexpected lsu_valid=%0d if_valid=%0d, expected none", k, l_vld[k], i_vld[k]);
        end else begin
          ok = (l_vld[k] == !r.port) && (i_vld[k] == r.port) &&
               ((r.port ? i_rdata[k] : l_rdata[k]) == r.rdata);
          if (!ok) begin
            n_err++;
            $display("FAIL resp[%0d]: got lsu_valid=%0d if_valid=%0d rdata=%h, expected port=%0d rdata=%h",
                     k, l_vld[k], i_vld[k], r.port ? i_rdata[k] : l_rdata[k], r.port, r.rdata);
          end
        end
      end
    end
  end

  initial begin
    RST = 1'b1;
    lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0;
    if_req = 0; if_addr = 0;
    mem_rdy = 0; mem_valid = 0; mem_rdata = 0;
    do_reset();

    // reset state, no requests
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_busy[%0d]", k), 32'(bsy[k]), 32'd0);
      chk($sformatf("reset_req[%0d]", k), 32'(m_req[k]), 32'd0);
      chk($sformatf("reset_hs[%0d]", k), 32'({l_rdy[k], i_rdy[k], l_vld[k], i_vld[k]}), 32'd0);
    end
    step();

    // single LSU write, zero-wait address, response next cycle
    lsu_req = 1; lsu_addr = 32'h100; lsu_we = 1; lsu_wdata = 32'hDEADBEEF;
    mem_rdy = 1; mem_valid = 0; mem_rdata = 32'hCAFE0001;
    for (int k = 0; k < 2; k++) begin
      push_g(k, 0, 32'h100, 1, 32'hDEADBEEF, 0);
      push_r(k, 0, 32'hCAFE0001);
    end
    @(negedge CLK);
    chk("wr_req_c0", 32'(m_req[0]), 32'd1);
    step();
    lsu_req = 0; lsu_we = 0; mem_valid = 1;
    @(negedge CLK);
    chk("wr_valid_c1", 32'(l_vld[0]), 32'd1);
    step();
    mem_valid = 0; mem_rdy = 0;
    step();

    // both requesting, zero-wait memory, 4 transactions from reset
    do_reset();
    lsu_addr = 32'h200; lsu_we = 1; lsu_wdata = 32'h11112222; if_addr = 32'h300;
    mem_rdata = 32'hA0A00001; mem_rdy = 1; mem_valid = 1;
    lsu_req = 1; if_req = 1;
    push_g(0, 0, 32'h200, 1, 32'h11112222, 0);
    push_g(0, 1, 32'h300, 0, 32'h0, 2);
    push_g(0, 0, 32'h200, 1, 32'h11112222, 2);
    push_g(0, 1, 32'h300, 0, 32'h0, 2);
    push_r(0, 0, 32'hA0A00001); push_r(0, 1, 32'hA0A00001);
    push_r(0, 0, 32'hA0A00001); push_r(0, 1, 32'hA0A00001);
    push_g(1, 0, 32'h200, 1, 32'h11112222, 0);
    for (int i = 0; i < 3; i++) push_g(1, 0, 32'h200, 1, 32'h11112222, 2);
    for (int i = 0; i < 4; i++) push_r(1, 0, 32'hA0A00001);
    repeat (8) step();
    lsu_req = 0; if_req = 0; lsu_we = 0; mem_rdy = 0; mem_valid = 0;
    step();

    // memory stall on IF fetch; LSU request arrives during the stall
    if_req = 1; if_addr = 32'h40; mem_rdata = 32'h12345678;
    for (int k = 0; k < 2; k++) begin
      push_g(k, 1, 32'h40, 0, 32'h0, 0);
      push_r(k, 1, 32'h12345678);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin lsu_req = 1; lsu_addr = 32'h500; lsu_we = 0; lsu_wdata = 32'h55; end
      if (i == 3) mem_rdy = 1;
      @(negedge CLK);
      chk($sformatf("stall_req_c%0d", i), 32'(m_req[0]), 32'd1);
      chk($sformatf("stall_addr_c%0d", i), m_addr[0], 32'h40);
      chk($sformatf("stall_lrdy_c%0d", i), 32'(l_rdy[0]), 32'd0);
      step();
    end
    // IF response with read data
    if_req = 0; mem_valid = 1;
    for (int k = 0; k < 2; k++) begin
      push_g(k, 0, 32'h500, 0, 32'h55, 2);
      push_r(k, 0, 32'h0BADF00D);
    end
    @(negedge CLK);
    chk("route_if_valid", 32'(i_vld[0]), 32'd1);
    chk("route_if_rdata", i_rdata[0], 32'h12345678);
    chk("route_lsu_valid", 32'(l_vld[0]), 32'd0);
    step();
    mem_rdata = 32'h0BADF00D;
    @(negedge CLK);
    chk("stall_lsu_grant", 32'(l_rdy[0]), 32'd1);
    step();
    lsu_req = 0;
    step();
    mem_valid = 0; mem_rdy = 0;
    step();

    // reset while waiting for the response
    lsu_req = 1; lsu_addr = 32'h600; lsu_we = 0; lsu_wdata = 32'h0; mem_rdy = 1;
    for (int k = 0; k < 2; k++) push_g(k, 0, 32'h600, 0, 32'h0, 0);
    step();
    lsu_req = 0; mem_rdy = 0; RST = 1;
    step();
    RST = 0;
    @(negedge CLK);
    chk("rst_busy_c2", 32'(bsy[0]), 32'd0);
    step();
    mem_valid = 1;
    @(negedge CLK);
    chk("rst_busy_c3", 32'(bsy[0]), 32'd0);
    chk("rst_valid_c3", 32'({l_vld[0], i_vld[0], l_vld[1], i_vld[1]}), 32'd0);
    step();
    mem_valid = 0;
    repeat (3) step();

    chk("gq0_empty", gq0.size(), 0);
    chk("gq1_empty", gq1.size(), 0);
    chk("rq0_empty", rq0.size(), 0);
    chk("rq1_empty", rq1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
